// File: rtl/dm_responder.sv
// Word-addressed data memory responder: clears itself after reset, then serves
// byte-enabled writes and combinational reads, flagging out-of-range writes.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(64'd4 << DEPTH_LOG2);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [31:0]           wr_count_q, wr_count_d;

  logic [31:0]           mem_q [0:DEPTH-1];

  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [31:0]           mem_wdata;
  logic [31:0]           old_word;

  always_comb begin
    offset   = m_data_addr - BASE_ADDR;
    in_range = ({1'b0, offset} < SPAN);
    idx      = offset[DEPTH_LOG2+1:2];
    old_word = mem_q[idx];

    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_widx   = idx;
    mem_wdata  = old_word;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        // Last word cleared on this edge: accesses are honoured from the next cycle.
        if (clr_idx_q == '1) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (|m_data_byteen) begin
          if (in_range) begin
            mem_we = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
              if (m_data_byteen[i]) mem_wdata[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
            wr_count_d = wr_count_q + 32'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase

    m_data_rdata = (ready_q && in_range) ? old_word : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Storage is not reset; the clear sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving log2 of the word count (4096 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port m_data_addr  input  32  byte address of the data access.
REQ-006 SHALL have port m_data_wdata  input  32  write data, byte lanes already positioned.
REQ-007 SHALL have port m_data_byteen  input  4  per-lane write enable; 4'b0000 means read/no write.
REQ-008 SHALL have port m_data_rdata  output  32  full word read data.
REQ-009 SHALL have port ready  output  1  high when clear sweep is done and accesses are honoured.
REQ-010 SHALL have port err  output  1  one-cycle pulse for a rejected write.
REQ-011 SHALL have port wr_count  output  32  number of committed writes since reset.

Function
REQ-012 SHALL hold DEPTH words of 32 bits; word index = (m_data_addr - BASE_ADDR) >> 2, with the low 2 address bits ignored.
REQ-013 SHALL treat an address as in range iff (m_data_addr - BASE_ADDR) < 4*DEPTH, computed as an unsigned 32-bit value.
REQ-014 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-015 SHALL, in CLEAR, write zero to word clr_idx on each rising edge and increment clr_idx, which is DEPTH_LOG2 bits wide.
REQ-016 SHALL, in CLEAR, go to IDLE and set ready on the edge that clears word DEPTH-1, so ready rises exactly DEPTH edges after reset deasserts.
REQ-017 SHALL stay in IDLE until the next reset.
REQ-018 SHALL drive m_data_rdata combinationally: mem[index] when ready and in range, otherwise 32'h0.
REQ-019 SHALL, in IDLE with |m_data_byteen, an in-range address and no reset, commit on the rising edge:
  - each lane i with byteen[i]=1 takes wdata[8i+7:8i];
  - every other lane keeps its old byte.
REQ-020 SHALL show pre-write data on m_data_rdata in the cycle of a write to that word, and the merged data from the following cycle.
REQ-021 SHALL increment wr_count by 1 per committed write, wrapping 32'hFFFF_FFFF -> 0.
REQ-022 SHALL drop an IDLE write with an out-of-range address (memory unchanged, wr_count unchanged) and set err high for exactly the next cycle.
REQ-023 SHALL ignore writes during CLEAR: no memory change, no count, no err.
REQ-024 SHALL keep err low for reads (byteen=0), whatever the address.
REQ-025 SHALL treat back-to-back writes to the same word as cumulative, the second merging onto the result of the first.

Reset
REQ-026 SHALL, while reset is high and independent of clk, force state=CLEAR, clr_idx=0, ready=0, err=0, wr_count=0.
REQ-027 SHALL restart the sweep from word 0 when reset is asserted mid-sweep or in IDLE; old contents are not guaranteed until ready rises again.
REQ-028 SHALL output m_data_rdata=0 whenever ready=0.

Verification
REQ-029 SHALL cover: reset high 5 cycles then low -> ready=0 for 4095 edges, ready=1 after edge 4096; read of addr 0x0000_3FFC returns 0.
REQ-030 SHALL cover: at IDLE, write addr 0x10, wdata 0x1122_3344, byteen 4'b1111, then write addr 0x12, wdata 0xAABB_0000, byteen 4'b1100 -> read 0x10 returns 0xAABB_3344 and wr_count=2.
REQ-031 SHALL cover: byteen 4'b0001, wdata 0x0000_00FF at addr 0x20 while addr is held -> rdata=0 during the write cycle and 0x0000_00FF on the next cycle.
REQ-032 SHALL cover: write to addr 0x0000_4000 (out of range), byteen 4'b1111 -> err=1 for one cycle, wr_count unchanged, rdata=0.
REQ-033 SHALL cover: write during CLEAR (cycle 100 after reset) -> ignored, err=0, and the word reads 0 after ready.
REQ-034 SHALL cover: reset pulsed asynchronously mid-clock in IDLE after writes -> ready, err and wr_count drop at once, a full DEPTH-edge sweep follows, and all previously written words read 0.
